// File: rtl/loop_sequencer_pkg.sv
// Shared types for the loop sequencer (string/REP-style iteration control).
package loop_sequencer_pkg;

   // Sequencer control states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_e;

endpackage : loop_sequencer_pkg

// File: rtl/loop_sequencer_count.sv
// Remaining-iteration counter: load, saturating decrement, zero/one detect.
module loop_sequencer_count #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             dec_i,
   output logic [WIDTH-1:0] remaining_o,
   output logic             zero_o,
   output logic             one_o
);

   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             zero_s;

   assign zero_s      = (count_q == CNT_ZERO);
   assign zero_o      = zero_s;
   assign one_o       = (count_q == CNT_ONE);
   assign remaining_o = count_q;

   // Next count: a load wins over a decrement; a decrement at zero holds zero.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && !zero_s) begin
         count_d = count_q - CNT_ONE;
      end else begin
         count_d = count_q;
      end
   end

   // Counter register with synchronous reset to zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= CNT_ZERO;
      end else begin
         count_q <= count_d;
      end
   end

endmodule : loop_sequencer_count

// File: rtl/loop_sequencer.sv
// Loop sequencer: issues count_in iteration handshakes, with early exit on
// terminate. Optional macro LOOP_SEQUENCER_YIELD_EN enables suspending the
// loop on a pending interrupt, leaving the unfinished count in remaining.
module loop_sequencer
   import loop_sequencer_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] count_in,
   output logic             step_valid,
   input  logic             step_ready,
   input  logic             terminate,
   input  logic             irq_pending,
   output logic [WIDTH-1:0] remaining,
   output logic             busy,
   output logic             done,
   output logic             yielded
);

   state_e state_q, state_d;
   logic   step_valid_q, step_valid_d;
   logic   busy_q, busy_d;
   logic   done_q, done_d;
   logic   yielded_q, yielded_d;
   logic   load_s, dec_s, hs_s;
   logic   rem_zero_s, rem_one_s;

`ifndef LOOP_SEQUENCER_YIELD_EN
   logic   unused_irq_s;
   assign unused_irq_s = irq_pending;
`endif

   loop_sequencer_count #(.WIDTH(WIDTH)) u_count (
      .clk         (clk),
      .reset       (reset),
      .load_i      (load_s),
      .load_val_i  (count_in),
      .dec_i       (dec_s),
      .remaining_o (remaining),
      .zero_o      (rem_zero_s),
      .one_o       (rem_one_s)
   );

   assign hs_s = step_valid_q && step_ready;

   // Next-state and next-output logic; final step/terminate outrank a yield.
   always_comb begin
      state_d   = state_q;
      load_s    = 1'b0;
      dec_s     = 1'b0;
      done_d    = 1'b0;
      yielded_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (count_in != {WIDTH{1'b0}}) begin
                  load_s  = 1'b1;
                  state_d = RUN;
               end else begin
                  done_d  = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (hs_s) begin
               dec_s = 1'b1;
               if (rem_one_s || rem_zero_s || terminate) begin
                  state_d = FINISH;
                  done_d  = 1'b1;
               end else begin
`ifdef LOOP_SEQUENCER_YIELD_EN
                  if (irq_pending) begin
                     state_d   = IDLE;
                     yielded_d = 1'b1;
                  end else begin
                     state_d = RUN;
                  end
`else
                  state_d = RUN;
`endif
               end
            end else begin
               state_d = RUN;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      step_valid_d = (state_d == RUN);
      busy_d       = (state_d != IDLE);
   end

   // State and registered-output flops; reset overrides any in-flight step.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         step_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         yielded_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         step_valid_q <= step_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         yielded_q    <= yielded_d;
      end
   end

   assign step_valid = step_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign yielded    = yielded_q;

endmodule : loop_sequencer

// File: tb/tb_loop_sequencer.sv
// Self-checking bench for loop_sequencer: table-driven per-cycle vectors plus
// a hand-written all-ones count run. Honours LOOP_SEQUENCER_YIELD_EN.
module tb_loop_sequencer;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset, start, step_ready, terminate, irq_pending;
   logic [W-1:0] count_in;
   logic         step_valid, busy, done, yielded;
   logic [W-1:0] remaining;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic         rst;
      logic         st;
      logic [W-1:0] cnt;
      logic         rdy;
      logic         term;
      logic         irq;
      logic         e_sv;
      logic [W-1:0] e_rem;
      logic         e_busy;
      logic         e_done;
      logic         e_yld;
   } vec_t;

   vec_t vecs[$];

   loop_sequencer #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .count_in    (count_in),
      .step_valid  (step_valid),
      .step_ready  (step_ready),
      .terminate   (terminate),
      .irq_pending (irq_pending),
      .remaining   (remaining),
      .busy        (busy),
      .done        (done),
      .yielded     (yielded)
   );

   always #5 clk = ~clk;

   // Append one cycle: inputs for the cycle and the outputs expected during it.
   function automatic void add(input logic r, input logic s, input logic [W-1:0] c,
                               input logic rd, input logic t, input logic q,
                               input logic sv, input logic [W-1:0] rem,
                               input logic b, input logic d, input logic y);
      vec_t v;
      v.rst = r; v.st = s; v.cnt = c; v.rdy = rd; v.term = t; v.irq = q;
      v.e_sv = sv; v.e_rem = rem; v.e_busy = b; v.e_done = d; v.e_yld = y;
      vecs.push_back(v);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [W-1:0] rem_after_yield;
      int           hs;
      logic         seen_done;

      reset = 1'b1; start = 1'b0; count_in = 16'd0;
      step_ready = 1'b0; terminate = 1'b0; irq_pending = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // reset state
      add(0,0,16'd0,0,0,0, 0,16'd0,0,0,0);
      // count 3, ready held high
      add(0,1,16'd3,1,0,0, 0,16'd0,0,0,0);
      add(0,0,16'd0,1,0,0, 1,16'd3,1,0,0);
      add(0,0,16'd0,1,0,0, 1,16'd2,1,0,0);
      add(0,0,16'd0,1,0,0, 1,16'd1,1,0,0);
      add(0,0,16'd0,1,0,0, 0,16'd0,1,1,0);
      add(0,0,16'd0,0,0,0, 0,16'd0,0,0,0);
      // count 0: done next cycle, no step, never busy
      add(0,1,16'd0,0,0,0, 0,16'd0,0,0,0);
      add(0,0,16'd0,0,0,0, 0,16'd0,0,1,0);
      add(0,0,16'd0,0,0,0, 0,16'd0,0,0,0);
      // count 4, ready 1,0,0,1,1,0,1; a start during RUN is ignored
      add(0,1,16'd4,0,0,0, 0,16'd0,0,0,0);
      add(0,0,16'd0,1,0,0, 1,16'd4,1,0,0);
      add(0,1,16'd9,0,0,0, 1,16'd3,1,0,0);
      add(0,0,16'd0,0,0,0, 1,16'd3,1,0,0);
      add(0,0,16'd0,1,0,0, 1,16'd3,1,0,0);
      add(0,0,16'd0,1,0,0, 1,16'd2,1,0,0);
      add(0,0,16'd0,0,0,0, 1,16'd1,1,0,0);
      add(0,0,16'd0,1,0,0, 1,16'd1,1,0,0);
      add(0,0,16'd0,0,0,0, 0,16'd0,1,1,0);
      add(0,0,16'd0,0,0,0, 0,16'd0,0,0,0);
      // count 10: terminate in a stall is ignored, on the 2nd handshake exits
      add(0,1,16'd10,0,0,0, 0,16'd0,0,0,0);
      add(0,0,16'd0,1,0,0, 1,16'd10,1,0,0);
      add(0,0,16'd0,0,1,0, 1,16'd9,1,0,0);
      add(0,0,16'd0,1,1,0, 1,16'd9,1,0,0);
      add(0,0,16'd0,0,0,0, 0,16'd8,1,1,0);
      add(0,0,16'd0,0,0,0, 0,16'd8,0,0,0);
      // count 6, reset after two handshakes overrides start and the step
      add(0,1,16'd6,0,0,0, 0,16'd8,0,0,0);
      add(0,0,16'd0,1,0,0, 1,16'd6,1,0,0);
      add(0,0,16'd0,1,0,0, 1,16'd5,1,0,0);
      add(1,1,16'd7,1,0,0, 1,16'd4,1,0,0);
      add(0,0,16'd0,0,0,0, 0,16'd0,0,0,0);
      add(0,0,16'd0,0,0,0, 0,16'd0,0,0,0);
      // fresh run after reset
      add(0,1,16'd2,0,0,0, 0,16'd0,0,0,0);
      add(0,0,16'd0,1,0,0, 1,16'd2,1,0,0);
      add(0,0,16'd0,1,0,0, 1,16'd1,1,0,0);
      add(0,0,16'd0,0,0,0, 0,16'd0,1,1,0);
      // reset during FINISH: nothing follows
      add(0,1,16'd1,0,0,0, 0,16'd0,0,0,0);
      add(0,0,16'd0,1,0,0, 1,16'd1,1,0,0);
      add(1,0,16'd0,0,0,0, 0,16'd0,1,1,0);
      add(0,0,16'd0,0,0,0, 0,16'd0,0,0,0);
      add(0,0,16'd0,0,0,0, 0,16'd0,0,0,0);
      // count 5, irq on the 2nd handshake
      add(0,1,16'd5,0,0,0, 0,16'd0,0,0,0);
      add(0,0,16'd0,1,0,0, 1,16'd5,1,0,0);
      add(0,0,16'd0,1,0,1, 1,16'd4,1,0,0);
`ifdef LOOP_SEQUENCER_YIELD_EN
      add(0,0,16'd0,0,0,0, 0,16'd3,0,0,1);
      add(0,0,16'd0,0,0,0, 0,16'd3,0,0,0);
      rem_after_yield = 16'd3;
`else
      add(0,0,16'd0,1,0,0, 1,16'd3,1,0,0);
      add(0,0,16'd0,1,0,0, 1,16'd2,1,0,0);
      add(0,0,16'd0,1,0,0, 1,16'd1,1,0,0);
      add(0,0,16'd0,0,0,0, 0,16'd0,1,1,0);
      add(0,0,16'd0,0,0,0, 0,16'd0,0,0,0);
      rem_after_yield = 16'd0;
`endif
      // count 5, irq on the final handshake: done only
      add(0,1,16'd5,0,0,0, 0,rem_after_yield,0,0,0);
      add(0,0,16'd0,1,0,0, 1,16'd5,1,0,0);
      add(0,0,16'd0,1,0,0, 1,16'd4,1,0,0);
      add(0,0,16'd0,1,0,0, 1,16'd3,1,0,0);
      add(0,0,16'd0,1,0,0, 1,16'd2,1,0,0);
      add(0,0,16'd0,1,0,1, 1,16'd1,1,0,0);
      add(0,0,16'd0,0,0,0, 0,16'd0,1,1,0);
      add(0,0,16'd0,0,0,0, 0,16'd0,0,0,0);

      for (int i = 0; i < vecs.size(); i++) begin
         reset       = vecs[i].rst;
         start       = vecs[i].st;
         count_in    = vecs[i].cnt;
         step_ready  = vecs[i].rdy;
         terminate   = vecs[i].term;
         irq_pending = vecs[i].irq;
         checks++;
         if (step_valid !== vecs[i].e_sv || remaining !== vecs[i].e_rem ||
             busy !== vecs[i].e_busy || done !== vecs[i].e_done ||
             yielded !== vecs[i].e_yld) begin
            failures++;
            $display("FAIL vec%0d: got sv=%b rem=%0d busy=%b done=%b yld=%b, want sv=%b rem=%0d busy=%b done=%b yld=%b",
                     i, step_valid, remaining, busy, done, yielded,
                     vecs[i].e_sv, vecs[i].e_rem, vecs[i].e_busy,
                     vecs[i].e_done, vecs[i].e_yld);
         end
         tick();
      end
      reset = 1'b0; start = 1'b0; step_ready = 1'b0;
      terminate = 1'b0; irq_pending = 1'b0;

      // all-ones count: exactly 2^W-1 handshakes, no wrap
      start = 1'b1; count_in = 16'hFFFF; step_ready = 1'b1;
      tick();
      start = 1'b0; count_in = 16'd0;
      checks++;
      if (step_valid !== 1'b1 || remaining !== 16'hFFFF) begin
         failures++;
         $display("FAIL allones_load: got sv=%b rem=%0d, want sv=1 rem=65535",
                  step_valid, remaining);
      end
      hs = 0;
      seen_done = 1'b0;
      for (int n = 0; n < 70000 && !seen_done; n++) begin
         if (step_valid && step_ready) hs++;
         if (done === 1'b1) seen_done = 1'b1;
         else tick();
      end
      checks++;
      if (!seen_done || hs != 65535 || remaining !== 16'd0) begin
         failures++;
         $display("FAIL allones_steps: got done_seen=%b steps=%0d rem=%0d, want done_seen=1 steps=65535 rem=0",
                  seen_done, hs, remaining);
      end
      step_ready = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || step_valid !== 1'b0) begin
         failures++;
         $display("FAIL allones_idle: got busy=%b done=%b sv=%b, want 0 0 0",
                  busy, done, step_valid);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_loop_sequencer

// File: doc/loop_sequencer.md
LOOP_SEQUENCER -- requirements
Module: loop_sequencer

Interface
REQ-001 Parameter WIDTH, default 16: iteration-count width, matching a CX-sized repeat count.
REQ-002 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port start, input, 1: single-cycle request to begin a loop; sampled only in IDLE.
REQ-005 Port count_in, input, WIDTH: number of iterations, captured when start is accepted.
REQ-006 Port step_valid, output, 1: an iteration is offered to the consumer.
REQ-007 Port step_ready, input, 1: the consumer accepts the offered iteration.
REQ-008 Port terminate, input, 1: early-exit condition (REPE/REPNE flag mismatch); qualified by the step handshake.
REQ-009 Port irq_pending, input, 1: interrupt pending; used only when the yield feature is compiled in.
REQ-010 Port remaining, output, WIDTH: iterations not yet accepted.
REQ-011 Port busy, output, 1: asserted while not in IDLE.
REQ-012 Port done, output, 1: one-cycle completion pulse.
REQ-013 Port yielded, output, 1: one-cycle pulse on suspension for an interrupt.

Function
REQ-014 The block SHALL implement three states: IDLE, RUN and FINISH.
REQ-015 IDLE + start + count_in != 0 SHALL load remaining = count_in and enter RUN on the next cycle.
REQ-016 IDLE + start + count_in == 0 SHALL stay in IDLE and pulse done in the next cycle, with no step issued.
REQ-017 start outside IDLE SHALL be ignored.
REQ-018 step_valid SHALL equal (state == RUN), be registered, and hold until accepted; it SHALL never depend combinationally on step_ready.
REQ-019 A handshake SHALL occur when step_valid && step_ready, and SHALL decrement remaining by 1 that cycle.
REQ-020 remaining SHALL saturate at 0 and never wrap; a load of all-ones SHALL issue exactly 2^WIDTH-1 steps.
REQ-021 A handshake with remaining == 1 SHALL enter FINISH.
REQ-022 A handshake with terminate == 1 SHALL enter FINISH; remaining SHALL still decrement for the accepted step.
REQ-023 terminate without a handshake SHALL be ignored.
REQ-024 FINISH SHALL assert done for exactly one cycle, deassert step_valid, then return to IDLE.
REQ-025 Latency: start to first step_valid SHALL be 1 cycle; last handshake to done SHALL be 1 cycle.
REQ-026 Priority on a handshake cycle SHALL be: final step / terminate > irq yield.
REQ-027 done and yielded SHALL never assert in the same cycle.

Reset
REQ-028 Reset SHALL force IDLE, remaining = 0, and step_valid, busy, done and yielded all 0, taking effect on the next edge.
REQ-029 Reset SHALL override start and any in-flight step, including mid-RUN and during FINISH; no done pulse SHALL follow.

Configuration
REQ-030 With macro LOOP_SEQUENCER_YIELD_EN defined, a handshake in RUN with irq_pending == 1 and post-decrement remaining != 0 SHALL:
- pulse yielded for one cycle;
- return to IDLE;
- leave remaining holding the unfinished count, so the owner can write it back to CX and restart.
REQ-031 Without LOOP_SEQUENCER_YIELD_EN, irq_pending SHALL be ignored and yielded SHALL be tied to 0; the port list SHALL be identical in both builds.

Structure
REQ-032 Package loop_sequencer_pkg SHALL hold the state enum (IDLE, RUN, FINISH).
REQ-033 The remaining counter (load, decrement, zero/one detect, saturation) SHALL be the sub-module loop_sequencer_count, instantiated once; the FSM stays in loop_sequencer.

Verification
REQ-034 start, count_in=3, step_ready=1 constant -> step_valid for 3 cycles, remaining 3->2->1->0, done in cycle 5, busy falls after done.
REQ-035 start, count_in=0 -> done next cycle, step_valid never asserts, busy stays 0.
REQ-036 count_in=4, step_ready toggling 1,0,0,1,1,0,1 -> exactly 4 handshakes, step_valid stable through stalls, done one cycle after the 4th.
REQ-037 count_in=10, terminate=1 on the 2nd handshake -> done next cycle, remaining=8; terminate asserted during a stall has no effect.
REQ-038 YIELD_EN build, count_in=5, irq_pending=1 on the 2nd handshake -> yielded pulse, remaining=3, IDLE; irq on the 5th handshake -> done only. Non-YIELD build: same stimulus -> 5 steps, done.
REQ-039 count_in=6, reset asserted after 2 handshakes -> next cycle IDLE, remaining=0, no done; a fresh start then runs normally.
